// File: rtl/count_controller.sv
// rtl/count_controller.sv - start/stop/clear controlled 4-digit BCD up/down counter
// All inputs except rst are asynchronous and synchronized onto fast_clock.
module count_controller #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] BCD_MAX     = 16'h9999
) (
  input  logic        fast_clock,
  input  logic        rst,
  input  logic        slow_clock,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic        up_down,
  output logic [15:0] count_bcd,
  output logic [1:0]  state,
  output logic        running,
  output logic        wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  // Bit order: [0] slow_clock, [1] start, [2] stop, [3] clear, [4] up_down
  logic [4:0]  async_in;
  logic [4:0]  sync_q [SYNC_STAGES];
  logic [4:0]  sync_s;
  logic [3:0]  edge_q;
  logic [2:0]  fill_q, fill_d;
  logic        fill_done;
  logic [2:0]  armed_q, armed_d;
  logic [2:0]  btn_rise;
  logic        tick;
  logic        cmd_start, cmd_stop, cmd_clear;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        running_q, running_d;
  logic        wrap_q, wrap_d;

  assign async_in = {up_down, btn_clear, btn_stop, btn_start, slow_clock};
  assign sync_s   = sync_q[SYNC_STAGES-1];

  // Synchronizer outputs are only trustworthy once the chain has refilled after reset.
  assign fill_done = (fill_q == 3'(SYNC_STAGES));
  assign fill_d    = fill_done ? fill_q : fill_q + 3'd1;

  // A button must be seen low after reset before its rising edges count.
  assign armed_d  = armed_q | ({3{fill_done}} & ~sync_s[3:1]);
  assign btn_rise = sync_s[3:1] & ~edge_q[3:1] & armed_q;
  assign tick     = sync_s[0] & ~edge_q[0];

  assign cmd_clear = btn_rise[2];
  assign cmd_stop  = btn_rise[1] & ~btn_rise[2];
  assign cmd_start = btn_rise[0] & ~btn_rise[1] & ~btn_rise[2];

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_start) state_d = ST_RUN;
      ST_RUN:   if (cmd_stop)  state_d = ST_PAUSE;
      ST_PAUSE: if (cmd_start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (cmd_clear) state_d = ST_IDLE;
  end

  // Counting keys off the registered state, so the entering-RUN tick is skipped
  // and a tick alongside stop still lands.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (cmd_clear) begin
      count_d = '0;
    end else if (tick && state_q == ST_RUN) begin
      if (sync_s[4]) begin
        if (count_q == BCD_MAX) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
        end
      end else begin
        if (count_q == 16'h0000) begin
          count_d = BCD_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end
  end

  assign running_d = (state_d == ST_RUN);

  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q    <= '0;
      fill_q    <= '0;
      armed_q   <= '0;
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q    <= sync_s[3:0];
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign count_bcd = count_q;
  assign state     = state_q;
  assign running   = running_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_count_controller.sv
// tb/tb_count_controller.sv - scoreboard bench for count_controller
module tb_count_controller;

  localparam int SS = 2;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10;

  logic        fast_clock = 1'b0;
  logic        rst        = 1'b0;
  logic        slow_clock = 1'b0;
  logic        btn_start  = 1'b0;
  logic        btn_stop   = 1'b0;
  logic        btn_clear  = 1'b0;
  logic        up_down    = 1'b1;
  logic [15:0] count_bcd;
  logic [1:0]  state;
  logic        running;
  logic        wrap;

  count_controller #(.SYNC_STAGES(SS), .BCD_MAX(16'h9999)) dut (
    .fast_clock (fast_clock),
    .rst        (rst),
    .slow_clock (slow_clock),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .btn_clear  (btn_clear),
    .up_down    (up_down),
    .count_bcd  (count_bcd),
    .state      (state),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 fast_clock = ~fast_clock;

  typedef struct packed {
    logic [15:0] count;
    logic [1:0]  st;
    logic        wrap;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_count = 0;
  logic [1:0] m_state = S_IDLE;
  logic       m_dir   = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic void push_model(input logic wr);
    exp_t e;
    e.count = to_bcd(m_count);
    e.st    = m_state;
    e.wrap  = wr;
    sb_q.push_back(e);
  endfunction

  function automatic void model_apply(input bit tk, input bit st, input bit sp, input bit cl);
    logic wr;
    wr = 1'b0;
    if (cl) begin
      m_count = 0;
      m_state = S_IDLE;
    end else begin
      if (tk && m_state == S_RUN) begin
        if (m_dir) begin
          if (m_count == 9999) begin m_count = 0; wr = 1'b1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = 9999; wr = 1'b1; end
          else m_count = m_count - 1;
        end
      end
      if (sp) begin
        if (m_state == S_RUN) m_state = S_PAUSE;
      end else if (st) begin
        m_state = S_RUN;
      end
    end
    push_model(wr);
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb"}, sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".count"},   count_bcd, e.count);
      check_eq({tag, ".state"},   state,     e.st);
      check_eq({tag, ".running"}, running,   e.st == S_RUN);
      check_eq({tag, ".wrap"},    wrap,      e.wrap);
    end
  endtask

  task automatic stim(input string tag, input bit tk, input bit st, input bit sp, input bit cl);
    @(negedge fast_clock);
    slow_clock = tk;
    btn_start  = st;
    btn_stop   = sp;
    btn_clear  = cl;
    model_apply(tk, st, sp, cl);
    repeat (SS + 1) @(posedge fast_clock);
    @(negedge fast_clock);
    sb_check(tag);
    @(negedge fast_clock);
    check_eq({tag, ".wrap1"}, wrap, 0);
    slow_clock = 1'b0;
    btn_start  = 1'b0;
    btn_stop   = 1'b0;
    btn_clear  = 1'b0;
    repeat (SS + 3) @(negedge fast_clock);
    check_eq({tag, ".hold"}, count_bcd, to_bcd(m_count));
  endtask

  task automatic set_dir(input bit d);
    @(negedge fast_clock);
    up_down = d;
    m_dir   = d;
    repeat (SS + 2) @(negedge fast_clock);
  endtask

  initial begin
    repeat (3) @(negedge fast_clock);
    push_model(1'b0);
    sb_check("reset");
    rst = 1'b1;
    repeat (SS + 4) @(negedge fast_clock);

    stim("start", 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) stim("up12", 1, 0, 0, 0);
    check_eq("up12.final", count_bcd, 16'h0012);

    stim("clear", 0, 0, 0, 1);
    stim("start2", 0, 1, 0, 0);
    set_dir(1'b0);
    stim("dn_wrap", 1, 0, 0, 0);
    stim("dn_9998", 1, 0, 0, 0);
    check_eq("dn.final", count_bcd, 16'h9998);
    set_dir(1'b1);
    stim("up_9999", 1, 0, 0, 0);
    stim("up_wrap", 1, 0, 0, 0);
    check_eq("upwrap.final", count_bcd, 16'h0000);

    for (int i = 0; i < 5; i++) stim("up5", 1, 0, 0, 0);
    stim("stop", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) stim("pause_tick", 1, 0, 0, 0);
    stim("resume", 0, 1, 0, 0);
    stim("resume_tick", 1, 0, 0, 0);
    check_eq("resume.final", count_bcd, 16'h0006);

    stim("tick_stop", 1, 0, 1, 0);
    stim("resume2", 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) stim("up_to9", 1, 0, 0, 0);
    stim("clr_tick", 1, 0, 0, 1);
    stim("start_tick", 1, 1, 0, 0);
    stim("all3", 0, 1, 1, 1);

    stim("start3", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) stim("pre_rst", 1, 0, 0, 0);
    @(negedge fast_clock);
    btn_start = 1'b1;
    rst       = 1'b0;
    #1;
    m_count = 0;
    m_state = S_IDLE;
    push_model(1'b0);
    sb_check("rst_mid");
    @(negedge fast_clock);
    rst = 1'b1;
    repeat (12) @(negedge fast_clock);
    push_model(1'b0);
    sb_check("held_start");
    btn_start = 1'b0;
    repeat (SS + 3) @(negedge fast_clock);
    push_model(1'b0);
    sb_check("released");
    stim("repress", 0, 1, 0, 0);
    stim("after_rst_tick", 1, 0, 0, 0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
